// File: rtl/io_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_tx_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               IO window base, register offsets (ioAddr[3:2]), STATUS bit
//               positions and the 2-bit transmit state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package io_uart_tx_pkg;

  localparam logic [31:0] IO_BASE = 32'h7000_0000;

  // Register offsets, word index taken from ioAddr[3:2]
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous byte FIFO with asynchronous active-high reset.
//               A push while full is accepted only when a pop happens in the
//               same cycle; otherwise it is dropped.
// Ports       : clk, rst      - clock / async reset
//               push_i, data_i - push request and byte
//               pop_i          - pop request (ignored while empty)
//               data_o         - head byte (valid while not empty)
//               full_o, empty_o, count_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [7:0]   data_i,
  input  logic         pop_i,
  output logic [7:0]   data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_push, w_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign w_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : io_uart_tx
// Description : Memory-mapped 8N1 UART transmitter. DATA writes feed a byte
//               FIFO drained by a START/DATA/STOP state machine at a bit
//               period of BAUDDIV+1 clocks.
// Ports       : clk, rst  - clock / async active-high reset
//               ioCe, ioWe, ioAddr, ioWtData - IO bus write side
//               ioRdData  - combinational read data (0 when ioCe=0)
//               txd       - serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioCe,
  input  logic        ioWe,
  input  logic [31:0] ioAddr,
  input  logic [31:0] ioWtData,
  output logic [31:0] ioRdData,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e      state_q, state_d;
  logic             txd_q, txd_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] baud_q;
  logic             ovf_q;

  logic             w_wr;
  logic [1:0]       w_sel;
  logic             w_push, w_pop;
  logic             w_full, w_empty;
  logic [7:0]       w_head;
  logic [CW-1:0]    w_count;
  logic [31:0]      w_count_ext;
  logic [31:0]      w_status;
  logic             w_bnd;
  logic             w_unused_bits;

  assign w_wr   = ioCe && ioWe;
  assign w_sel  = ioAddr[3:2];
  assign w_push = w_wr && (w_sel == REG_DATA);

  io_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (ioWtData[7:0]),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // --------------------------------------------------------------------------
  // Software-visible registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q <= DIV_W'(DEFAULT_DIV);
      ovf_q  <= 1'b0;
    end else begin
      if (w_wr && (w_sel == REG_BAUDDIV)) baud_q <= ioWtData[DIV_W-1:0];
      if (w_wr && (w_sel == REG_STATUS) && ioWtData[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign w_count_ext = 32'(w_count);

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]  = (state_q != ST_IDLE);
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_OVF]   = ovf_q;
    w_status[STAT_CNT_LSB +: STAT_CNT_W] = w_count_ext[STAT_CNT_W-1:0];
  end

  always_comb begin
    ioRdData = '0;
    if (ioCe) begin
      case (w_sel)
        REG_STATUS:  ioRdData = w_status;
        REG_BAUDDIV: ioRdData = 32'(baud_q);
        default:     ioRdData = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit state machine
  // --------------------------------------------------------------------------
  // The boundary compare uses the live BAUDDIV value, so a smaller value
  // written mid-bit lets the counter run on until it wraps.
  assign w_bnd = (div_q == baud_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = '0;
    w_pop   = 1'b0;

    if (state_q != ST_IDLE) begin
      div_d = w_bnd ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          shift_d = w_head;
          w_pop   = 1'b1;
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_bnd) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bnd) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_bnd) begin
          // Chain straight into the next frame when more data is queued.
          if (!w_empty) begin
            shift_d = w_head;
            w_pop   = 1'b1;
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign txd = txd_q;

  // Address and data bits outside the decoded fields are intentionally ignored.
  assign w_unused_bits = ^{ioAddr, ioWtData, w_count_ext};

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_uart_tx
// Description : Directed self-checking bench for io_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_tx;

  localparam logic [31:0] A_DATA   = 32'h7000_0000;
  localparam logic [31:0] A_STATUS = 32'h7000_0004;
  localparam logic [31:0] A_BAUD   = 32'h7000_0008;
  localparam logic [31:0] A_RSVD   = 32'h7000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ioCe = 1'b0;
  logic        ioWe = 1'b0;
  logic [31:0] ioAddr = '0;
  logic [31:0] ioWtData = '0;
  logic [31:0] ioRdData;
  logic        txd;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_bytes [16];
  int         exp_n;

  io_uart_tx #(
    .FIFO_DEPTH  (8),
    .DIV_W       (16),
    .DEFAULT_DIV (433)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ioCe     (ioCe),
    .ioWe     (ioWe),
    .ioAddr   (ioAddr),
    .ioWtData (ioWtData),
    .ioRdData (ioRdData),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  // Write on the next rising edge; returns 1 time unit after that edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ioCe = 1'b1; ioWe = 1'b1; ioAddr = addr; ioWtData = data;
    @(posedge clk);
    #1;
    ioWe = 1'b0; ioCe = 1'b0; ioWtData = '0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    ioCe = 1'b1; ioWe = 1'b0; ioAddr = addr;
    #1;
    data = ioRdData;
  endtask

  // Compares txd clock by clock against the 8N1 frames of exp_bytes, starting
  // at frame-clock index 'start' (0 = first clock of the first start bit).
  task automatic check_stream(input int p, input int start);
    int total, f, b, busy_bad;
    logic e;
    int first_bad [16];
    logic bad_got [16];
    logic [31:0] st;
    busy_bad = 0;
    for (int i = 0; i < 16; i++) begin
      first_bad[i] = -1;
      bad_got[i] = 1'b0;
    end
    ioCe = 1'b1; ioWe = 1'b0; ioAddr = A_STATUS;
    #1;
    total = exp_n * 10 * p;
    for (int idx = start; idx < total; idx++) begin
      f = idx / (10 * p);
      b = (idx % (10 * p)) / p;
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = exp_bytes[f][b-1];
      if (txd !== e && first_bad[f] < 0) begin
        first_bad[f] = idx;
        bad_got[f] = txd;
      end
      if (ioRdData[0] !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
    end
    for (int fr = start / (10 * p); fr < exp_n; fr++) begin
      checks++;
      if (first_bad[fr] >= 0) begin
        failures++;
        $display("FAIL frame%0d_txd clock %0d: got %b want %b", fr,
                 first_bad[fr], bad_got[fr], ~bad_got[fr]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL busy_during_frame: %0d clocks with busy=0, want 0", busy_bad);
    end
    rd(A_STATUS, st);
    checks++;
    if (st !== 32'h0000_0004) begin
      failures++;
      $display("FAIL status_after_frames: got %h want 00000004", st);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", txd); end
    rd(A_STATUS, v);
    checks++;
    if (v !== 32'h0000_0004) begin failures++; $display("FAIL reset_status: got %h want 00000004", v); end
    rd(A_BAUD, v);
    checks++;
    if (v !== 32'd433) begin failures++; $display("FAIL reset_bauddiv: got %0d want 433", v); end
    rd(A_DATA, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL data_read: got %h want 0", v); end
    rd(A_RSVD, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL rsvd_read: got %h want 0", v); end
    ioCe = 1'b0; ioAddr = A_STATUS;
    #1;
    checks++;
    if (ioRdData !== 32'h0) begin failures++; $display("FAIL ce_low_read: got %h want 0", ioRdData); end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    wr(A_BAUD, 32'hABCD_0003);
    rd(A_BAUD, v);
    checks++;
    if (v !== 32'h0000_0003) begin failures++; $display("FAIL baud_upper_bits: got %h want 00000003", v); end
    wr(A_DATA, 32'h0000_0055);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL txd_before_first_edge: got %b want 1", txd); end
    @(posedge clk); #1;
    exp_bytes[0] = 8'h55;
    exp_n = 1;
    check_stream(4, 0);
  endtask

  task automatic test_back_to_back();
    wr(A_BAUD, 32'd0);
    wr(A_DATA, 32'h0000_00A5);
    wr(A_DATA, 32'h0000_003C);
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h3C;
    exp_n = 2;
    check_stream(1, 0);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    wr(A_BAUD, 32'd7);
    for (int i = 0; i < 10; i++) wr(A_DATA, 32'(8'h10 + i));
    rd(A_STATUS, v);
    checks++;
    if (v !== 32'h0000_080B) begin failures++; $display("FAIL overflow_status: got %h want 0000080b", v); end
    wr(A_STATUS, 32'h0000_0008);
    rd(A_STATUS, v);
    checks++;
    if (v !== 32'h0000_0803) begin failures++; $display("FAIL overflow_clear: got %h want 00000803", v); end
    for (int i = 0; i < 9; i++) exp_bytes[i] = 8'(8'h10 + i);
    exp_n = 9;
    check_stream(8, 9);
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    wr(A_BAUD, 32'd0);
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'(8'h80 + i));
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr(A_DATA, 32'h0000_0089);
    rd(A_STATUS, v);
    checks++;
    if (v !== 32'h0000_0803) begin failures++; $display("FAIL full_pop_status: got %h want 00000803", v); end
    for (int i = 0; i < 10; i++) exp_bytes[i] = 8'(8'h80 + i);
    exp_n = 10;
    check_stream(1, 10);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int bad;
    wr(A_BAUD, 32'd3);
    wr(A_DATA, 32'h0000_00C3);
    repeat (14) begin @(posedge clk); #1; end
    checks++;
    if (txd !== 1'b0) begin failures++; $display("FAIL mid_frame_bit2: got %b want 0", txd); end
    rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL async_reset_txd: got %b want 1", txd); end
    @(negedge clk);
    rst = 1'b0;
    rd(A_STATUS, v);
    checks++;
    if (v !== 32'h0000_0004) begin failures++; $display("FAIL post_reset_status: got %h want 00000004", v); end
    rd(A_BAUD, v);
    checks++;
    if (v !== 32'd433) begin failures++; $display("FAIL post_reset_baud: got %0d want 433", v); end
    ioAddr = A_STATUS;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || ioRdData[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL post_reset_idle: %0d active clocks, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the IO side of the memory/IO controller; decodes the 0x7000_0000 IO window.
- Consumes ioCe/ioWe/ioAddr/ioWtData and returns ioRdData combinationally.
- Writes to DATA push bytes into a small FIFO; a bit-serial state machine drains it onto txd as 8N1 frames at a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor register.
- DEFAULT_DIV, 433, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ioCe  in  1  IO chip enable, active-high.
- ioWe  in  1  IO write enable, active-high; qualified by ioCe.
- ioAddr  in  32  byte address; only bits [3:2] decoded.
- ioWtData  in  32  write data.
- ioRdData  out  32  read data; combinational from ioCe/ioAddr and the register state.
- txd  out  1  serial output, idle high.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: txd=1, state IDLE, FIFO empty (pointers and count 0), BAUDDIV=DEFAULT_DIV, overflow=0, bit counter and divider counter 0. Reset mid-frame aborts the frame; txd returns to 1 immediately.
- Register map (ioAddr[3:2]):
  - 0 DATA: write pushes ioWtData[7:0]; reads return 0.
  - 1 STATUS (read): bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] FIFO count, other bits 0. Writing 1 to bit3 clears overflow; other write bits are ignored.
  - 2 BAUDDIV: read/write, low DIV_W bits; upper read bits 0.
  - 3: reserved; reads 0, writes ignored.
- Writes take effect on the rising clk edge when ioCe=1 and ioWe=1. With ioCe=0, ioRdData=0.
- Push to a full FIFO:
  - Byte dropped and overflow set.
  - Exception: if a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Pushes into an empty FIFO are not bypassed.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO is non-empty on an edge: load head into shifter, pop, txd<=0, divider counter<=0, go to START. txd therefore falls one clock after the write edge.
  - Divider counter counts 0..BAUDDIV. Each bit lasts exactly BAUDDIV+1 clocks. A bit boundary occurs when counter==BAUDDIV.
  - START to DATA at the boundary: txd<=shifter[0] (LSB first), bit index 0.
  - DATA: 8 bits. After bit 7's boundary, txd<=1 and go to STOP.
  - STOP: one bit period of 1. At the boundary, if FIFO is non-empty, go directly to START with the next byte (back-to-back frames, no idle gap); otherwise go to IDLE.
- BAUDDIV=0 gives 1 clock per bit. A BAUDDIV write mid-frame is sampled by the boundary compare immediately; if the new value is below the current count, the bit ends when the counter wraps at 2^DIV_W−1. Software writes BAUDDIV only while busy=0.
- Frame length: 10*(BAUDDIV+1) clocks.

Decomposition:
- Add to define.v:
  - IO base 32'h7000_0000.
  - Register offsets: DATA 0, STATUS 1, BAUDDIV 2.
  - STATUS bit positions.
  - UART state encodings (2 bits).
- One sub-module: io_fifo (parameterised synchronous byte FIFO with push, pop, full, empty, count, and async active-high reset).
- The top level holds register decode, the divider, and the FSM.

Test Plan:
- Reset, then read STATUS with ioCe=1, ioAddr=0x7000_0004 -> 0x0000_0004, txd=1; read BAUDDIV -> 433.
- Write BAUDDIV=3, write DATA=0x55 -> txd low from the next edge for 4 clocks, then bits 1,0,1,0,1,0,1,0 for 4 clocks each, then stop 1 for 4 clocks. Total 40 clocks; busy=1 throughout, then 0.
- BAUDDIV=0, write 0xA5 and 0x3C back-to-back -> 20 contiguous clocks of frames (0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1) with no idle gap.
- BAUDDIV=7, write 10 bytes in 10 consecutive cycles:
  - First byte pops, 8 fill the FIFO, 10th is dropped.
  - STATUS count=8, full=1, overflow=1.
  - Write STATUS=0x8 -> overflow=0.
  - Exactly 9 frames are transmitted.
- Push while full in the same cycle as a STOP-to-START pop -> byte accepted, count stays 8, no overflow.
- Assert rst for one cycle in the middle of the DATA bits -> txd=1 asynchronously, STATUS reads 0x4, BAUDDIV reads 433, no further frames.
